// File: rtl/irrigation_valve_fsm.sv
// ---------------------------------------------------------------------------
// irrigation_valve_fsm
//
// Decides when the irrigation valve opens and closes, based on the 3-bit
// saturating dryness level (0 = wet, 7 = driest). Evaluation happens on a slow
// time-base strobe (tick). Provides:
//   - a confirmation filter before opening (CONFIRM_TICKS qualifying ticks)
//   - a minimum on-time (MIN_ON_TICKS) with hysteresis between OFF/ON levels
//   - a maximum on-time watchdog that latches FAULT (MAX_ON_TICKS)
//   - a post-watering soak period that ignores the level (SOAK_TICKS)
//
// Ports
//   clock        in   1  system clock, rising edge
//   reset        in   1  synchronous, active-high
//   level        in   3  dryness level
//   tick         in   1  one-cycle time-base strobe
//   enable       in   1  system enable; 0 forces IDLE (except from FAULT)
//   clear_fault  in   1  leaves FAULT
//   valve        out  1  1 = valve open (state == WATER)
//   fault        out  1  1 while state == FAULT
//   water_done   out  1  one-cycle pulse on the cycle after WATER->SOAK
//   state        out  3  IDLE=0 CONFIRM=1 WATER=2 SOAK=3 FAULT=4
//
// All outputs come from registers (state register, water_done flop); there is
// no combinational path from any input to any output.
// ---------------------------------------------------------------------------
module irrigation_valve_fsm #(
    parameter int ON_LEVEL      = 5,
    parameter int OFF_LEVEL     = 2,
    parameter int CONFIRM_TICKS = 3,
    parameter int MIN_ON_TICKS  = 4,
    parameter int MAX_ON_TICKS  = 20,
    parameter int SOAK_TICKS    = 6,
    parameter int TIMER_W       = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] level,
    input  logic       tick,
    input  logic       enable,
    input  logic       clear_fault,
    output logic       valve,
    output logic       fault,
    output logic       water_done,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CONFIRM = 3'd1,
        WATER   = 3'd2,
        SOAK    = 3'd3,
        FAULT   = 3'd4
    } state_t;

    localparam logic [2:0]         ON_LVL   = 3'(ON_LEVEL);
    localparam logic [2:0]         OFF_LVL  = 3'(OFF_LEVEL);
    localparam logic [TIMER_W-1:0] CONF_T   = TIMER_W'(CONFIRM_TICKS);
    localparam logic [TIMER_W-1:0] MIN_T    = TIMER_W'(MIN_ON_TICKS);
    localparam logic [TIMER_W-1:0] MAX_T    = TIMER_W'(MAX_ON_TICKS);
    localparam logic [TIMER_W-1:0] SOAK_T   = TIMER_W'(SOAK_TICKS);

    state_t               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 done_q, done_d;
    logic [TIMER_W-1:0]   timer_inc;

    // Every state that advances its timer on a tick uses timer+1; the parameter
    // limits guarantee it never wraps.
    assign timer_inc = timer_q + TIMER_W'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        done_d  = 1'b0;

        case (state_q)
            FAULT: begin
                // Latched: only clear_fault (or reset) leaves, no tick needed.
                if (clear_fault) begin
                    state_d = IDLE;
                    timer_d = '0;
                end
            end

            IDLE, CONFIRM, WATER, SOAK: begin
                if (!enable) begin
                    // Forced close: immediate, silent (no water_done).
                    state_d = IDLE;
                    timer_d = '0;
                end else if (tick) begin
                    case (state_q)
                        IDLE: begin
                            if (level >= ON_LVL) begin
                                state_d = CONFIRM;
                                timer_d = TIMER_W'(1);
                            end
                        end
                        CONFIRM: begin
                            if (level < ON_LVL) begin
                                state_d = IDLE;
                                timer_d = '0;
                            end else if (timer_inc == CONF_T) begin
                                state_d = WATER;
                                timer_d = '0;
                            end else begin
                                timer_d = timer_inc;
                            end
                        end
                        WATER: begin
                            // Watchdog wins over a normal close on the same tick.
                            if (timer_inc == MAX_T) begin
                                state_d = FAULT;
                                timer_d = '0;
                            end else if (timer_inc >= MIN_T && level <= OFF_LVL) begin
                                state_d = SOAK;
                                timer_d = '0;
                                done_d  = 1'b1;
                            end else begin
                                timer_d = timer_inc;
                            end
                        end
                        SOAK: begin
                            if (timer_inc == SOAK_T) begin
                                state_d = IDLE;
                                timer_d = '0;
                            end else begin
                                timer_d = timer_inc;
                            end
                        end
                        default: begin
                            state_d = IDLE;
                            timer_d = '0;
                        end
                    endcase
                end
            end

            // Unused encodings recover to IDLE.
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    assign state      = state_q;
    assign valve      = (state_q == WATER);
    assign fault      = (state_q == FAULT);
    assign water_done = done_q;

endmodule

// File: tb/tb_irrigation_valve_fsm.sv
// ---------------------------------------------------------------------------
// tb_irrigation_valve_fsm
//
// Directed scenarios with default parameters, tick every 4 clocks. Each driven
// cycle pushes the expected {state, valve, fault, water_done} onto exp_q; after
// the clock edge the DUT outputs are sampled and compared against the popped
// entry. Expected states come from the behavioural description, not the DUT.
// ---------------------------------------------------------------------------
module tb_irrigation_valve_fsm;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CONFIRM = 3'd1;
    localparam logic [2:0] S_WATER   = 3'd2;
    localparam logic [2:0] S_SOAK    = 3'd3;
    localparam logic [2:0] S_FAULT   = 3'd4;

    // clock / reset and DUT signals
    logic       clock;
    logic       reset;
    logic [2:0] level;
    logic       tick;
    logic       enable;
    logic       clear_fault;
    logic       valve;
    logic       fault;
    logic       water_done;
    logic [2:0] state;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    irrigation_valve_fsm dut (
        .clock       (clock),
        .reset       (reset),
        .level       (level),
        .tick        (tick),
        .enable      (enable),
        .clear_fault (clear_fault),
        .valve       (valve),
        .fault       (fault),
        .water_done  (water_done),
        .state       (state)
    );

    // scoreboard
    logic [5:0] exp_q[$];
    int         checks;
    int         failures;
    logic [2:0] cur_exp;

    task automatic check_eq(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got {state,valve,fault,done}=%b_%b_%b_%b expected %b_%b_%b_%b",
                     tag, obs[5:3], obs[2], obs[1], obs[0], exp[5:3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Drive one clock cycle of stimulus, push the expectation, compare after the edge.
    task automatic cyc(input logic t, input logic [2:0] lv, input logic en, input logic clr,
                       input logic rst, input logic [2:0] es, input logic ewd, input string tag);
        logic [5:0] exp_v;
        tick        = t;
        level       = lv;
        enable      = en;
        clear_fault = clr;
        reset       = rst;
        exp_q.push_back({es, (es == S_WATER), (es == S_FAULT), ewd});
        @(posedge clock);
        #1;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            exp_v = exp_q.pop_front();
            check_eq(tag, {state, valve, fault, water_done}, exp_v);
        end
        cur_exp = es;
        tick        = 1'b0;
        clear_fault = 1'b0;
        reset       = 1'b0;
    endtask

    // Three idle cycles (state must hold) then one tick cycle.
    task automatic period(input logic [2:0] lv, input logic en, input logic [2:0] es,
                          input logic ewd, input string tag);
        for (int i = 0; i < 3; i++) cyc(1'b0, lv, en, 1'b0, 1'b0, cur_exp, 1'b0, {tag, "_hold"});
        cyc(1'b1, lv, en, 1'b0, 1'b0, es, ewd, tag);
    endtask

    task automatic go_water();
        period(3'd6, 1'b1, S_CONFIRM, 1'b0, "gw_t1");
        period(3'd6, 1'b1, S_CONFIRM, 1'b0, "gw_t2");
        period(3'd6, 1'b1, S_WATER,   1'b0, "gw_t3");
    endtask

    // From IDLE: reach WATER, hold level 7 for 19 ticks, 20th tick with level 1
    // still faults because the watchdog outranks closing.
    task automatic go_fault();
        go_water();
        for (int i = 1; i < 20; i++) period(3'd7, 1'b1, S_WATER, 1'b0, "wd_water");
        period(3'd1, 1'b1, S_FAULT, 1'b0, "wd_fault20");
    endtask

    initial begin
        checks = 0;
        failures = 0;
        cur_exp = S_IDLE;
        tick = 1'b0; level = 3'd0; enable = 1'b0; clear_fault = 1'b0; reset = 1'b1;

        // reset state
        cyc(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, S_IDLE, 1'b0, "reset0");
        cyc(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, S_IDLE, 1'b0, "reset1");

        // enable low ignores a dry tick
        period(3'd7, 1'b0, S_IDLE, 1'b0, "dis_idle");
        // clear_fault outside FAULT does nothing
        cyc(1'b0, 3'd7, 1'b1, 1'b1, 1'b0, S_IDLE, 1'b0, "clr_idle");

        // 1: open after three qualifying ticks
        go_water();

        // hysteresis: level between OFF and ON keeps valve open
        period(3'd3, 1'b1, S_WATER, 1'b0, "hyst_t1");
        // 3: level 1 -> close only once min on-time reached (timer 1 -> n=2,3,4)
        period(3'd1, 1'b1, S_WATER, 1'b0, "min_t2");
        period(3'd1, 1'b1, S_WATER, 1'b0, "min_t3");
        period(3'd1, 1'b1, S_SOAK,  1'b1, "close_t4");
        // water_done must drop after one cycle; soak ignores level 7
        for (int i = 1; i < 6; i++) period(3'd7, 1'b1, S_SOAK, 1'b0, "soak");
        period(3'd7, 1'b1, S_IDLE, 1'b0, "soak_end");

        // 2: confirm aborted when level falls below ON_LEVEL
        period(3'd6, 1'b1, S_CONFIRM, 1'b0, "abort_t1");
        period(3'd6, 1'b1, S_CONFIRM, 1'b0, "abort_t2");
        period(3'd4, 1'b1, S_IDLE,    1'b0, "abort_t3");

        // minimal close exactly at MIN_ON_TICKS from a fresh open
        go_water();
        for (int i = 1; i < 4; i++) period(3'd2, 1'b1, S_WATER, 1'b0, "min_edge");
        period(3'd2, 1'b1, S_SOAK, 1'b1, "min_edge_close");
        cyc(1'b0, 3'd2, 1'b0, 1'b0, 1'b0, S_IDLE, 1'b0, "dis_soak");

        // 5: enable low mid-WATER between ticks -> IDLE, no water_done
        go_water();
        cyc(1'b0, 3'd7, 1'b1, 1'b0, 1'b0, S_WATER, 1'b0, "w_hold");
        cyc(1'b0, 3'd7, 1'b0, 1'b0, 1'b0, S_IDLE,  1'b0, "dis_water");
        cyc(1'b0, 3'd7, 1'b1, 1'b0, 1'b0, S_IDLE,  1'b0, "dis_after");

        // 4: watchdog fault, then hold regardless of tick/level/enable
        go_fault();
        for (int i = 0; i < 10; i++)
            period(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), S_FAULT, 1'b0, "fault_hold");
        // clear_fault without tick -> IDLE next edge
        cyc(1'b0, 3'd7, 1'b1, 1'b1, 1'b0, S_IDLE, 1'b0, "clear_fault");

        // 6: reset dominates tick, level and clear_fault in FAULT
        go_fault();
        period(3'd7, 1'b0, S_FAULT, 1'b0, "fault_dis");
        cyc(1'b1, 3'd7, 1'b1, 1'b1, 1'b1, S_IDLE, 1'b0, "reset_fault");
        // timer was cleared: a fresh confirm needs the full three ticks
        go_water();

        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute watchdog on the whole run.
    initial begin
        #500000;
        $display("FAIL timeout: run exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
